dmux_stream_1ton: RTL and testbench
===================================

// Module: dmux_stream_1ton
// PURPOSE
//  Registered, parametrised 1-to-N demultiplexer for streaming data with valid/ready handshake.
//  - Each input word is routed to one selected output channel, or to all channels in broadcast mode.
//  - Each channel holds one output register, so a stalled channel does not corrupt data on the others.
//  - Successor to the combinational 8-bit 1-to-4 demux; sits between a single producer and N consumers.
// PARAMETERS
//  WIDTH  8  data word width in bits
//  N      4  number of output channels (N >= 2)
//  SEL_W  2  selector width; N <= 2**SEL_W is required
//  CNT_W  8  width of the saturating dropped-word counter
// PORTS
//  clk       in   1        rising-edge clock
//  rst_n     in   1        asynchronous active-low reset
//  in_data   in   WIDTH    input word
//  in_sel    in   SEL_W    destination channel index
//  in_bcast  in   1        1 = copy the word to all N channels; in_sel is ignored
//  in_valid  in   1        input word present
//  in_ready  out  1        block accepts the word this cycle
//  out_data  out  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
//  out_valid out  N        channel k register holds a word
//  out_ready in   N        consumer k takes its word
//  drop_cnt  out  CNT_W    count of words dropped because in_sel >= N (saturating)
// BEHAVIOUR
//  Reset (async, rst_n=0)
//  - Forces out_valid=0, out_data=0 and drop_cnt=0 immediately, independent of clk.
//  - A word held in any channel is discarded.
//  - The first transfer is possible on the first rising edge after rst_n returns to 1.
//  Channel k state machine
//  - Two states: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
//  - drain_k = out_valid[k] & out_ready[k].
//  - load_k  = accept & (in_bcast | in_sel==k).
//  - EMPTY + load_k -> FULL; out_data[k] <= in_data.
//  - FULL + drain_k + !load_k -> EMPTY; out_data[k] keeps its last value.
//  - FULL + drain_k + load_k -> FULL with the new word. Back-to-back transfers give no bubble.
//  - FULL + !drain_k: the register holds its data; a load into this channel is impossible (in_ready=0).
//  Input handshake (in_ready is combinational; no dependence on in_valid)
//  - free_k = !out_valid[k] | out_ready[k].
//  - in_bcast=1: in_ready = AND of free_k over all k. Broadcast is all-or-nothing; no channel is written partially.
//  - in_bcast=0, in_sel<N: in_ready = free_{in_sel}.
//  - in_bcast=0, in_sel>=N: in_ready=1. The word is dropped, no channel changes, and drop_cnt increments.
//  - accept = in_valid & in_ready. A word accepted at edge t is visible on out_data/out_valid after edge t (1-cycle latency).
//  Counter rules
//  - drop_cnt saturates at 2**CNT_W-1 and never wraps.
//  Other rules
//  - in_sel, in_bcast and in_data are sampled only on accept; their values are don't-care otherwise.
//  - Channels drain independently; out_ready[k] has no effect while out_valid[k]=0.
// TESTING
//  Directed scenarios (defaults WIDTH=8, N=4 unless stated)
//  1 Reset: assert rst_n=0 mid-stream with ch2 FULL -> out_valid=4'b0000 and drop_cnt=0 before the next clk edge.
//  2 Sweep: in_data=8'hFF, in_sel=0..3 on consecutive cycles, out_ready=4'hF
//    -> each of out_valid 4'b0001, 4'b0010, 4'b0100, 4'b1000 high for one cycle in turn; matching slice=8'hFF.
//  3 Stall: out_ready[1]=0; send 8'hA5 then 8'h3C to ch1
//    -> second word sees in_ready=0; out_data[15:8] stays 8'hA5 until out_ready[1]=1, then 8'h3C loads one cycle later.
//  4 Broadcast: in_bcast=1, in_data=8'h5A with ch3 FULL and stalled -> in_ready=0 and no channel is written;
//    release ch3 -> all four channels show 8'h5A and out_valid=4'hF.
//  5 Drop: build N=3, SEL_W=2; send in_sel=3 twice -> in_ready=1, out_valid unchanged, drop_cnt=2.
//    Build CNT_W=2 and send 5 drops -> drop_cnt=3 (saturated).
//  6 Throughput: in_valid=1 continuously, in_sel alternating 0/1, out_ready=4'hF
//    -> one accept every cycle; the data sequence on each channel matches the input order.

Source files
------------

// File: rtl/dmux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with valid/ready handshake.
// Each channel owns one output register; broadcast loads all channels atomically.

module dmux_stream_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             free
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (load) state_nxt = FULL;
            FULL:    if (ready && !load) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Data keeps its last value after draining; only a load replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    data <= '0;
        else if (load) data <= din;
    end

    assign valid = (state == FULL);
    assign free  = !valid | ready;
endmodule

module dmux_stream_1ton #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic                 in_bcast,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [CNT_W-1:0]     drop_cnt
);
    logic [N-1:0] sel_hit;
    logic [N-1:0] free;
    logic [N-1:0] load;
    logic         sel_ok;
    logic         accept;
    logic         drop;

    assign sel_ok = ({1'b0, in_sel} < (SEL_W+1)'(N));

    // Out-of-range selectors are always ready so the producer never blocks on them.
    assign in_ready = in_bcast ? (&free) : (!sel_ok | (|(sel_hit & free)));
    assign accept   = in_valid & in_ready;
    assign drop     = accept & !in_bcast & !sel_ok;

    for (genvar k = 0; k < N; k++) begin : g_chan
        assign sel_hit[k] = (in_sel == SEL_W'(k));
        assign load[k]    = accept & (in_bcast | sel_hit[k]);

        dmux_stream_chan #(.WIDTH(WIDTH)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[k]),
            .din   (in_data),
            .ready (out_ready[k]),
            .data  (out_data[k*WIDTH +: WIDTH]),
            .valid (out_valid[k]),
            .free  (free[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (drop && (drop_cnt != {CNT_W{1'b1}}))
            drop_cnt <= drop_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_dmux_stream_1ton.sv
// Randomised and directed checks of dmux_stream_1ton against a channel-level model.
// A second small build (N=3, CNT_W=2) exercises dropping and counter saturation.

module tb_dmux_stream_1ton;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [7:0]  in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        in_bcast = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [7:0]  drop_cnt;

    logic [7:0]  d3_data = '0;
    logic [1:0]  d3_sel = '0;
    logic        d3_bcast = 1'b0;
    logic        d3_valid = 1'b0;
    logic        d3_in_ready;
    logic [23:0] d3_out_data;
    logic [2:0]  d3_out_valid;
    logic [2:0]  d3_out_ready = '0;
    logic [1:0]  d3_drop;

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0]      mval = '0;
    logic [3:0][7:0] mdat = '0;

    always #5 clk = ~clk;

    dmux_stream_1ton #(.WIDTH(8), .N(4), .SEL_W(2), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop_cnt(drop_cnt)
    );

    dmux_stream_1ton #(.WIDTH(8), .N(3), .SEL_W(2), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d3_data), .in_sel(d3_sel), .in_bcast(d3_bcast),
        .in_valid(d3_valid), .in_ready(d3_in_ready),
        .out_data(d3_out_data), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
        .drop_cnt(d3_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("out_valid", 32'(out_valid), 32'(mval));
        chk("out_data", out_data, mdat);
        chk("drop_cnt_n4", 32'(drop_cnt), 32'd0);
    endtask

    // One handshake cycle: check registered outputs, drive, check in_ready, advance model.
    task automatic cycle(input logic [7:0] d, input logic [1:0] s, input logic b,
                         input logic v, input logic [3:0] ordy, output logic acc);
        logic [3:0] mfree;
        logic       exp_rdy;
        @(negedge clk);
        chk_outputs();
        in_data = d; in_sel = s; in_bcast = b; in_valid = v; out_ready = ordy;
        #1;
        mfree   = ~mval | ordy;
        exp_rdy = b ? (mfree == 4'hF) : mfree[s];
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v & exp_rdy;
        for (int k = 0; k < 4; k++) begin
            if (acc && (b || s == 2'(k))) begin
                mval[k] = 1'b1;
                mdat[k] = d;
            end else if (ordy[k]) begin
                mval[k] = 1'b0;
            end
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc;
        int   nacc;

        #1;
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_data", out_data, 32'h0);
        chk("reset_drop", 32'(drop_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sweep: one word per channel, each visible for exactly one cycle.
        for (int i = 0; i < 4; i++) begin
            cycle(8'hFF, 2'(i), 1'b0, 1'b1, 4'hF, acc);
            settle();
            chk("sweep_onehot", 32'(out_valid), 32'(4'b0001 << i));
            chk("sweep_slice", 32'(out_data[i*8 +: 8]), 32'hFF);
        end
        cycle(8'h00, 2'd0, 1'b0, 1'b0, 4'hF, acc);

        // Stall on ch1.
        cycle(8'hA5, 2'd1, 1'b0, 1'b1, 4'b1101, acc);
        cycle(8'h3C, 2'd1, 1'b0, 1'b1, 4'b1101, acc);
        chk("stall_blocked", 32'(acc), 32'd0);
        settle();
        chk("stall_hold", 32'(out_data[15:8]), 32'hA5);
        cycle(8'h3C, 2'd1, 1'b0, 1'b1, 4'b1111, acc);
        settle();
        chk("stall_reload", 32'(out_data[15:8]), 32'h3C);

        // Broadcast blocked by a stalled ch3, then released.
        cycle(8'h33, 2'd3, 1'b0, 1'b1, 4'b0000, acc);
        cycle(8'h5A, 2'd2, 1'b1, 1'b1, 4'b0111, acc);
        chk("bcast_blocked", 32'(acc), 32'd0);
        settle();
        chk("bcast_nowrite", out_data[31:24], 32'h33);
        cycle(8'h5A, 2'd1, 1'b1, 1'b1, 4'b1111, acc);
        settle();
        chk("bcast_valid", 32'(out_valid), 32'hF);
        chk("bcast_data", out_data, 32'h5A5A5A5A);

        // Throughput: one accept per cycle alternating ch0/ch1.
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(8'(8'h10 + i), 2'(i % 2), 1'b0, 1'b1, 4'hF, acc);
            if (acc) nacc++;
        end
        chk("throughput", 32'(nacc), 32'd8);
        cycle(8'h00, 2'd0, 1'b0, 1'b0, 4'h0, acc);

        // Drop and saturation on the N=3, CNT_W=2 build; main DUT idles meanwhile.
        @(negedge clk);
        in_valid = 1'b0; out_ready = 4'h0;
        d3_data = 8'h42; d3_sel = 2'd0; d3_valid = 1'b1; d3_out_ready = 3'b000;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            d3_sel = 2'd3; d3_data = 8'(i);
            #1;
            chk("drop_ready", 32'(d3_in_ready), 32'd1);
            settle();
            chk("drop_cnt", 32'(d3_drop), (i < 3) ? 32'(i) : 32'd3);
            chk("drop_valid", 32'(d3_out_valid), 32'b001);
            chk("drop_data", d3_out_data, 32'h000042);
        end
        @(negedge clk);
        d3_valid = 1'b0;

        // Asynchronous reset mid-stream with ch2 full.
        cycle(8'h77, 2'd2, 1'b0, 1'b1, 4'b0000, acc);
        settle();
        chk("pre_reset_ch2", 32'(out_valid), 32'(mval));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'h0);
        chk("async_data", out_data, 32'h0);
        chk("async_drop", 32'(d3_drop), 32'h0);
        chk("async_valid3", 32'(d3_out_valid), 32'h0);
        mval = '0; mdat = '0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(8'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), 4'($urandom), acc);
        end
        cycle(8'h00, 2'd0, 1'b0, 1'b0, 4'h0, acc);
        @(negedge clk);
        chk_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
